// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB3 bus bundle between the master driver and the memory completer
//
// Purpose: groups the APB3 request/response signals so that master and
//          completer can each take one port.
// Signals: paddr[31:0], pselx, penable, pwrite, pwdata[31:0]   master -> completer
//          pready, prdata[31:0], pslverr                        completer -> master
// Modports: master (drives requests), slave (drives responses)
interface apb_slave_mem_if;
  logic [31:0] paddr;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 completer backed by a word-addressed register memory
//
// Purpose: accepts APB3 transfers, inserts WAIT_STATES access-phase wait cycles,
//          reads/writes a DEPTH x 32-bit memory and flags misaligned or
//          out-of-range addresses with pslverr.
// Ports:   pclk      APB clock, rising-edge state updates
//          preset_n  asynchronous active-low reset (clears FSM and memory)
//          s         apb_slave_mem_if.slave bus (paddr/pselx/penable/pwrite/pwdata in,
//                    pready/prdata/pslverr out)
module apb_slave_mem #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic          pclk,
  input  logic          preset_n,
  apb_slave_mem_if.slave s
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The setup phase is the IDLE cycle in which pselx=1, penable=0 is seen:
  // that is where address/control are latched, so the registered state only
  // needs to distinguish "waiting for a setup" from "in the access phase".
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              write_q, write_d;
  logic              err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [31:0] offset;
  logic        setup_err;
  logic        done;
  logic        viol;
  logic        wr_en;

  always_comb begin
    offset    = s.paddr - BASE_ADDR;
    // BASE_ADDR is word aligned, so offset[1:0] equals paddr[1:0].
    setup_err = (offset[1:0] != 2'b00) ||
                (s.paddr < BASE_ADDR) ||
                ((offset >> 2) >= 32'(DEPTH));

    // Completion needs the completer still selected; dropping pselx aborts.
    done = (state_q == ACCESS) && s.pselx && (cnt_q == 3'd0);
    // Access phase without a preceding setup: answer with an error at once.
    viol = preset_n && (state_q == IDLE) && s.pselx && s.penable;

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s.pselx && !s.penable) begin
          state_d = ACCESS;
          idx_d   = offset[IDXW+1:2];
          write_d = s.pwrite;
          err_d   = setup_err;
          cnt_d   = 3'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!s.pselx) begin
          state_d = IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = IDLE;
          wr_en   = write_q && !err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[idx_q] <= s.pwdata;
    end
  end

  assign s.pready  = done || viol;
  assign s.pslverr = (done && err_q) || viol;
  assign s.prdata  = (done && !write_q && !err_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed bench for apb_slave_mem with 1 and 0 wait states
//
// Purpose: drives one shared APB request bus into two completers (WAIT_STATES=1
//          and WAIT_STATES=0); sel picks which one is selected and observed.
// Ports:   none (top-level bench)
module tb_apb_slave_mem;
  logic        pclk = 1'b0;
  logic        preset_n;
  logic        sel;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int checks;
  int errors;

  apb_slave_mem_if bus0 ();
  apb_slave_mem_if bus1 ();

  assign bus0.paddr   = paddr;
  assign bus0.pwrite  = pwrite;
  assign bus0.pwdata  = pwdata;
  assign bus0.penable = penable;
  assign bus0.pselx   = pselx & ~sel;
  assign bus1.paddr   = paddr;
  assign bus1.pwrite  = pwrite;
  assign bus1.pwdata  = pwdata;
  assign bus1.penable = penable;
  assign bus1.pselx   = pselx & sel;

  assign pready  = sel ? bus1.pready  : bus0.pready;
  assign pslverr = sel ? bus1.pslverr : bus0.pslverr;
  assign prdata  = sel ? bus1.prdata  : bus0.prdata;

  apb_slave_mem #(.DATA_WIDTH(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .s        (bus1)
  );

  apb_slave_mem #(.DATA_WIDTH(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .s        (bus0)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    pselx   = 1'b0;
    penable = 1'b0;
  endtask

  // One transfer: setup then access until pready. Address/direction are
  // scrambled during the access phase; the completer must use latched values.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int n);
    logic got;
    got = 1'b0;
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    n = 1;
    @(negedge pclk);
    chk("setup_pready", {31'b0, pready}, 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1; paddr = a ^ 32'h40; pwrite = ~w;
    n = 2;
    for (int k = 0; k < 16; k++) begin
      @(negedge pclk);
      if (pready) begin
        got = 1'b1;
        break;
      end
      @(posedge pclk); #1;
      n++;
    end
    chk("xfer_completes", {31'b0, got}, 32'd1);
    rd = prdata;
    er = pslverr;
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;

  initial begin
    checks = 0; errors = 0;
    sel = 1'b1; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    preset_n = 1'b0;

    // 1. reset held three clocks, bus idle
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("rst_pready",  {31'b0, pready},  32'd0);
      chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
      chk("rst_prdata",  prdata,           32'd0);
    end
    preset_n = 1'b1;

    // 2. one wait state: write then read 0x10
    xfer(32'h10, 1'b1, 32'hDEAD_BEEF, rd, er, n);
    chk("ws1_wr_cycles", 32'(n), 32'd3);
    chk("ws1_wr_err",    {31'b0, er}, 32'd0);
    chk("ws1_wr_prdata", rd, 32'd0);
    go_idle();
    xfer(32'h10, 1'b0, 32'h0, rd, er, n);
    chk("ws1_rd_cycles", 32'(n), 32'd3);
    chk("ws1_rd_data",   rd, 32'hDEAD_BEEF);
    chk("ws1_rd_err",    {31'b0, er}, 32'd0);
    go_idle();

    // 3. zero wait states: back-to-back write then read at 0x0
    sel = 1'b0;
    xfer(32'h0, 1'b1, 32'h1, rd, er, n);
    chk("ws0_wr_cycles", 32'(n), 32'd2);
    xfer(32'h0, 1'b0, 32'h0, rd, er, n);
    chk("ws0_rd_cycles", 32'(n), 32'd2);
    chk("ws0_rd_data",   rd, 32'h1);
    go_idle();
    sel = 1'b1;

    // 4. error paths and the last valid word
    xfer(32'h102, 1'b0, 32'h0, rd, er, n);
    chk("mis_rd_err",    {31'b0, er}, 32'd1);
    chk("mis_rd_data",   rd, 32'd0);
    chk("mis_rd_cycles", 32'(n), 32'd3);
    go_idle();
    xfer(32'h100, 1'b1, 32'hCAFE_F00D, rd, er, n);
    chk("oor_wr_err",    {31'b0, er}, 32'd1);
    chk("oor_wr_cycles", 32'(n), 32'd3);
    go_idle();
    xfer(32'h11, 1'b1, 32'h0000_1234, rd, er, n);
    chk("mis_wr_err",    {31'b0, er}, 32'd1);
    go_idle();
    xfer(32'h10, 1'b0, 32'h0, rd, er, n);
    chk("after_err_0x10", rd, 32'hDEAD_BEEF);
    go_idle();
    xfer(32'h0, 1'b0, 32'h0, rd, er, n);
    chk("after_err_0x0", rd, 32'd0);
    go_idle();
    xfer(32'hFC, 1'b1, 32'hA5A5_A5A5, rd, er, n);
    chk("last_wr_err", {31'b0, er}, 32'd0);
    xfer(32'hFC, 1'b0, 32'h0, rd, er, n);
    chk("last_rd_data", rd, 32'hA5A5_A5A5);
    chk("last_rd_err",  {31'b0, er}, 32'd0);
    go_idle();

    // protocol violation: access phase straight from IDLE
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h0BAD;
    @(negedge pclk);
    chk("viol_pready",  {31'b0, pready},  32'd1);
    chk("viol_pslverr", {31'b0, pslverr}, 32'd1);
    chk("viol_prdata",  prdata,           32'd0);
    go_idle();
    @(negedge pclk);
    chk("viol_idle_pready", {31'b0, pready}, 32'd0);
    xfer(32'h10, 1'b0, 32'h0, rd, er, n);
    chk("viol_no_write", rd, 32'hDEAD_BEEF);
    chk("viol_then_ok_cycles", 32'(n), 32'd3);
    go_idle();

    // 5. reset during the access wait of a write to 0x8
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h77;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("rstw_wait_pready", {31'b0, pready}, 32'd0);
    #1 preset_n = 1'b0;
    #1 chk("rstw_now_pready", {31'b0, pready}, 32'd0);
    @(negedge pclk);
    chk("rstw_held_pready",  {31'b0, pready},  32'd0);
    chk("rstw_held_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rstw_held_prdata",  prdata,           32'd0);
    pselx = 1'b0; penable = 1'b0;
    #1 preset_n = 1'b1;
    xfer(32'h8, 1'b0, 32'h0, rd, er, n);
    chk("rstw_rd_0x8", rd, 32'd0);
    go_idle();
    xfer(32'h10, 1'b0, 32'h0, rd, er, n);
    chk("rstw_rd_0x10_cleared", rd, 32'd0);
    go_idle();

    // 6. master abort during the access wait of a write 0x55 @0x4
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h55;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort_wait_pready", {31'b0, pready}, 32'd0);
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready",  {31'b0, pready},  32'd0);
    chk("abort_pslverr", {31'b0, pslverr}, 32'd0);
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("abort_after_pready", {31'b0, pready}, 32'd0);
    xfer(32'h4, 1'b0, 32'h0, rd, er, n);
    chk("abort_rd_0x4", rd, 32'd0);
    go_idle();

    repeat (2) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
